// File: rtl/sxr_mem_arbiter.sv
// Three-requester round-robin arbiter (fetch, data, IO) in front of one
// single-port synchronous RAM; every output is registered.
module sxr_mem_arbiter #(
  parameter int DW = 14,
  parameter int AW = 14
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          dm_gnt,
  output logic          dm_rvalid,
  input  logic          io_req,
  input  logic [AW-1:0] io_addr,
  output logic          io_gnt,
  output logic          io_rvalid,
  output logic [DW-1:0] rdata,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [1:0] SRC_IF = 2'd0;
  localparam logic [1:0] SRC_DM = 2'd1;
  localparam logic [1:0] SRC_IO = 2'd2;

  state_t      state_reg;
  logic [1:0]  last_reg;
  logic [1:0]  owner_reg;
  logic [2:0]  gnt_reg;
  logic [2:0]  rvalid_reg;

  logic [2:0]    req_vec;
  logic          win_valid;
  logic [1:0]    win_idx;
  logic [AW-1:0] win_addr;
  logic          win_we;

  assign req_vec = {io_req, dm_req, if_req};

  // Requester index k positions after base, wrapping over the three sources.
  function automatic logic [1:0] rr_next(input logic [1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= 3) s = s - 3;
    return s[1:0];
  endfunction

  // Scan from farthest to nearest so the requester right after the last
  // winner overrides everyone else.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = last_reg;
    for (int k = 3; k >= 1; k--) begin
      if (req_vec[rr_next(last_reg, k)]) begin
        win_valid = 1'b1;
        win_idx   = rr_next(last_reg, k);
      end
    end
  end

  always_comb begin
    win_addr = if_addr;
    win_we   = 1'b0;
    case (win_idx)
      SRC_DM: begin
        win_addr = dm_addr;
        win_we   = dm_we;
      end
      SRC_IO:  win_addr = io_addr;
      default: win_addr = if_addr;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_reg  <= IDLE;
      last_reg   <= SRC_IO;
      owner_reg  <= SRC_IF;
      gnt_reg    <= 3'b000;
      rvalid_reg <= 3'b000;
      mem_addr   <= '0;
      mem_we     <= 1'b0;
      mem_wdata  <= '0;
      rdata      <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          rvalid_reg <= 3'b000;
          if (win_valid) begin
            owner_reg <= win_idx;
            last_reg  <= win_idx;
            gnt_reg   <= 3'(3'b001 << win_idx);
            mem_addr  <= win_addr;
            mem_we    <= win_we;
            if (win_idx == SRC_DM) begin
              mem_wdata <= dm_wdata;
            end
            state_reg <= ACCESS;
          end else begin
            gnt_reg <= 3'b000;
          end
        end
        ACCESS: begin
          gnt_reg <= 3'b000;
          mem_we  <= 1'b0;
          // Stores finish here; reads need one more cycle for the RAM output.
          state_reg <= mem_we ? IDLE : RESP;
        end
        RESP: begin
          rdata      <= mem_rdata;
          rvalid_reg <= 3'(3'b001 << owner_reg);
          state_reg  <= IDLE;
        end
        default: begin
          gnt_reg    <= 3'b000;
          rvalid_reg <= 3'b000;
          mem_we     <= 1'b0;
          state_reg  <= IDLE;
        end
      endcase
    end
  end

  assign if_gnt    = gnt_reg[0];
  assign dm_gnt    = gnt_reg[1];
  assign io_gnt    = gnt_reg[2];
  assign if_rvalid = rvalid_reg[0];
  assign dm_rvalid = rvalid_reg[1];
  assign io_rvalid = rvalid_reg[2];

endmodule

// File: tb/tb_sxr_mem_arbiter.sv
// Randomised and directed bench for sxr_mem_arbiter against a transaction-level
// model: grant times, read-return times and RAM contents tracked per cycle.
module tb_sxr_mem_arbiter;
  localparam int DW   = 14;
  localparam int AW   = 14;
  localparam int MAXC = 4096;

  logic          Clock = 1'b0;
  logic          Reset = 1'b1;
  logic          if_req = 1'b0, dm_req = 1'b0, dm_we = 1'b0, io_req = 1'b0;
  logic [AW-1:0] if_addr = '0, dm_addr = '0, io_addr = '0;
  logic [DW-1:0] dm_wdata = '0;
  logic          if_gnt, if_rvalid, dm_gnt, dm_rvalid, io_gnt, io_rvalid;
  logic [DW-1:0] rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;

  sxr_mem_arbiter #(.DW(DW), .AW(AW)) dut (
    .Clock(Clock), .Reset(Reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid),
    .io_req(io_req), .io_addr(io_addr), .io_gnt(io_gnt), .io_rvalid(io_rvalid),
    .rdata(rdata), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 Clock = ~Clock;

  function automatic logic [DW-1:0] init_word(input int a);
    if (a == 16) return DW'(14'h1ABC);
    return DW'(a * 37 + 5);
  endfunction

  // Synchronous RAM seen by the DUT: one-cycle read latency.
  logic [DW-1:0] ram [0:(1<<AW)-1];
  logic          ram_ready = 1'b0;
  always @(posedge Clock) begin
    if (!ram_ready) begin
      for (int i = 0; i < (1 << AW); i++) ram[i] <= init_word(i);
      ram_ready <= 1'b1;
    end else begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
    end
  end

  // Reference model: per-cycle expectations filled in when a grant is decided.
  int            checks = 0, failures = 0;
  int            cyc = 0, free_cyc = 0, last_w = 2;
  logic [2:0]    exp_gnt [MAXC];
  logic [2:0]    exp_rv  [MAXC];
  logic          exp_we  [MAXC];
  logic [AW-1:0] exp_addr[MAXC];
  logic [DW-1:0] exp_wd  [MAXC];
  logic [DW-1:0] exp_rd  [MAXC];
  logic [DW-1:0] ref_ram [0:(1<<AW)-1];
  logic [DW-1:0] ref_rdata = '0;
  logic [AW-1:0] ref_maddr = '0;
  int            q_code[$];
  int            q_cyc[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_edge();
    logic [2:0]    reqs;
    int            w;
    logic [AW-1:0] a;
    logic          we;
    reqs = {io_req, dm_req, if_req};
    w = -1;
    if (cyc >= free_cyc) begin
      for (int k = 1; k <= 3; k++) begin
        if (w < 0 && reqs[(last_w + k) % 3]) w = (last_w + k) % 3;
      end
    end
    if (w >= 0) begin
      last_w = w;
      a  = (w == 0) ? if_addr : (w == 1) ? dm_addr : io_addr;
      we = (w == 1) && dm_we;
      exp_gnt[cyc]  = 3'(1 << w);
      exp_addr[cyc] = a;
      exp_we[cyc]   = we;
      if (we) begin
        exp_wd[cyc] = dm_wdata;
        ref_ram[a]  = dm_wdata;
        free_cyc    = cyc + 2;
      end else begin
        exp_rv[cyc+2] = 3'(1 << w);
        exp_rd[cyc+2] = ref_ram[a];
        free_cyc      = cyc + 3;
      end
      $display("txn cyc=%0d src=%0d we=%0b addr=%0h", cyc, w, we, a);
    end
  endtask

  task automatic compare();
    check_eq("gnt", {io_gnt, dm_gnt, if_gnt}, exp_gnt[cyc]);
    check_eq("rvalid", {io_rvalid, dm_rvalid, if_rvalid}, exp_rv[cyc]);
    check_eq("mem_we", mem_we, exp_we[cyc]);
    if (exp_gnt[cyc] != 3'b000) ref_maddr = exp_addr[cyc];
    check_eq("mem_addr", mem_addr, ref_maddr);
    if (exp_we[cyc]) check_eq("mem_wdata", mem_wdata, exp_wd[cyc]);
    if (exp_rv[cyc] != 3'b000) ref_rdata = exp_rd[cyc];
    check_eq("rdata", rdata, ref_rdata);
  endtask

  task automatic step();
    @(posedge Clock);
    cyc++;
    if (cyc + 3 >= MAXC) begin
      $display("FAIL cycle_budget cycle=%0d limit=%0d", cyc, MAXC);
      $fatal(1, "cycle budget exhausted");
    end
    if (!Reset) model_edge();
    @(negedge Clock);
    compare();
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_gnt"}, {io_gnt, dm_gnt, if_gnt}, 3'b000);
    check_eq({tag, "_rvalid"}, {io_rvalid, dm_rvalid, if_rvalid}, 3'b000);
    check_eq({tag, "_mem_we"}, mem_we, 1'b0);
    check_eq({tag, "_mem_addr"}, mem_addr, '0);
    check_eq({tag, "_mem_wdata"}, mem_wdata, '0);
    check_eq({tag, "_rdata"}, rdata, '0);
  endtask

  // Raise Reset between edges and confirm the outputs clear without a clock.
  task automatic assert_reset(input string tag);
    Reset = 1'b1;
    #1;
    check_all_zero(tag);
    for (int i = cyc; i <= cyc + 3; i++) begin
      exp_gnt[i] = 3'b000;
      exp_rv[i]  = 3'b000;
      exp_we[i]  = 1'b0;
    end
    free_cyc  = 0;
    last_w    = 2;
    ref_rdata = '0;
    ref_maddr = '0;
  endtask

  task automatic drop_reqs();
    if_req = 1'b0; dm_req = 1'b0; io_req = 1'b0; dm_we = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < MAXC; i++) begin
      exp_gnt[i] = 3'b000; exp_rv[i] = 3'b000; exp_we[i] = 1'b0;
      exp_addr[i] = '0; exp_wd[i] = '0; exp_rd[i] = '0;
    end
    for (int i = 0; i < (1 << AW); i++) ref_ram[i] = init_word(i);

    // Power-on reset held for a few edges.
    repeat (3) step();
    check_all_zero("reset");

    // Scenario 1: single fetch read.
    Reset = 1'b0;
    if_req = 1'b1; if_addr = AW'(16'h0010);
    step();
    check_eq("s1_if_gnt", if_gnt, 1'b1);
    step();
    step();
    check_eq("s1_if_rvalid", if_rvalid, 1'b1);
    check_eq("s1_rdata", rdata, 14'h1ABC);
    drop_reqs();
    step();

    // Scenario 2: data store.
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = AW'(16'h0200); dm_wdata = DW'(16'h0155);
    step();
    check_eq("s2_mem_we", mem_we, 1'b1);
    check_eq("s2_mem_addr", mem_addr, 14'h0200);
    check_eq("s2_mem_wdata", mem_wdata, 14'h0155);
    drop_reqs();
    repeat (3) begin
      step();
      check_eq("s2_mem_we_low", mem_we, 1'b0);
      check_eq("s2_dm_rvalid", dm_rvalid, 1'b0);
    end

    // Scenario 3: all three reads held from reset.
    assert_reset("s3_rst");
    if_req = 1'b1; dm_req = 1'b1; dm_we = 1'b0; io_req = 1'b1;
    if_addr = AW'(16'h0010); dm_addr = AW'(16'h0200); io_addr = AW'(16'h0033);
    repeat (2) step();
    Reset = 1'b0;
    repeat (12) begin
      step();
      if ({io_gnt, dm_gnt, if_gnt} != 3'b000) begin
        q_code.push_back(int'({io_gnt, dm_gnt, if_gnt}));
        q_cyc.push_back(cyc);
      end
    end
    check_eq("s3_grant_count", q_code.size(), 4);
    if (q_code.size() >= 4) begin
      check_eq("s3_order0", q_code[0], 1);
      check_eq("s3_order1", q_code[1], 2);
      check_eq("s3_order2", q_code[2], 4);
      check_eq("s3_order3", q_code[3], 1);
      for (int i = 0; i < 3; i++) check_eq("s3_spacing", q_cyc[i+1] - q_cyc[i], 3);
    end
    drop_reqs();
    repeat (3) step();

    // Scenario 4: reset in the RESP cycle of an IO read.
    io_req = 1'b1; io_addr = AW'(16'h0044);
    step();
    check_eq("s4_io_gnt", io_gnt, 1'b1);
    io_req = 1'b0;
    step();
    #2;
    assert_reset("s4_rst");
    if_req = 1'b1; dm_req = 1'b1; dm_we = 1'b0; dm_addr = AW'(16'h0005);
    repeat (2) begin
      step();
      check_eq("s4_io_rvalid", io_rvalid, 1'b0);
    end
    Reset = 1'b0;
    step();
    check_eq("s4_first_gnt", {io_gnt, dm_gnt, if_gnt}, 3'b001);
    drop_reqs();
    repeat (3) step();

    // Scenario 5: IO request appears only while a data read is in ACCESS.
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = AW'(16'h0007);
    step();
    dm_req = 1'b0; io_req = 1'b1; io_addr = AW'(16'h0099);
    step();
    io_req = 1'b0;
    repeat (4) begin
      step();
      check_eq("s5_io_gnt", io_gnt, 1'b0);
    end

    // Randomised traffic over a small address window to exercise RAW hazards.
    for (int t = 0; t < 1500; t++) begin
      if_req   = ($urandom_range(0, 99) < 45);
      dm_req   = ($urandom_range(0, 99) < 45);
      io_req   = ($urandom_range(0, 99) < 35);
      dm_we    = $urandom_range(0, 1) == 1;
      if_addr  = AW'($urandom_range(0, 63));
      dm_addr  = AW'($urandom_range(0, 63));
      io_addr  = AW'($urandom_range(0, 63));
      dm_wdata = DW'($urandom);
      step();
    end
    drop_reqs();
    repeat (4) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
